// File: rtl/y86_regfile_sb.sv
// Y86 register file with two read ports, two write ports, optional write-to-read
// bypass and a per-register pending-write scoreboard that drives the decode stall.
module y86_regfile_sb #(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       NUM_REGS = 15,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       BYPASS   = 1,
    parameter int unsigned       SP_IDX   = 4,
    parameter logic [DATA_W-1:0] SP_RESET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   srcA,
    input  logic [ADDR_W-1:0]   srcB,
    output logic [DATA_W-1:0]   valA,
    output logic [DATA_W-1:0]   valB,
    input  logic [ADDR_W-1:0]   dstE,
    input  logic [DATA_W-1:0]   valE,
    input  logic [ADDR_W-1:0]   dstM,
    input  logic [DATA_W-1:0]   valM,
    input  logic                wb_en,
    input  logic                mark_en,
    input  logic [ADDR_W-1:0]   mark_dstE,
    input  logic [ADDR_W-1:0]   mark_dstM,
    output logic                stall,
    output logic [NUM_REGS-1:0] pend,
    input  logic [ADDR_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_data
);

    localparam logic BYP = (BYPASS != 0);

    function automatic logic is_valid(input logic [ADDR_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              we_e;
    logic              we_m;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;
    logic              covered_a;
    logic              covered_b;

    assign we_e = wb_en && is_valid(dstE);
    assign we_m = wb_en && is_valid(dstM);

    // Register array and scoreboard; M beats E on a shared destination, a new mark beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
            pend <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (we_m && dstM == ADDR_W'(i)) begin
                    regs[i] <= valM;
                end else if (we_e && dstE == ADDR_W'(i)) begin
                    regs[i] <= valE;
                end

                if (mark_en && (mark_dstE == ADDR_W'(i) || mark_dstM == ADDR_W'(i))) begin
                    pend[i] <= 1'b1;
                end else if ((we_e && dstE == ADDR_W'(i)) || (we_m && dstM == ADDR_W'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Stored contents; invalid indices read as zero.
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        dbg_data = '0;
        if (is_valid(srcA)) begin
            stored_a = regs[srcA];
        end
        if (is_valid(srcB)) begin
            stored_b = regs[srcB];
        end
        if (is_valid(dbg_addr)) begin
            dbg_data = regs[dbg_addr];
        end
    end

    // Read ports with optional forwarding of the write happening this cycle.
    always_comb begin
        valA = stored_a;
        valB = stored_b;
        if (BYP && we_m && dstM == srcA) begin
            valA = valM;
        end else if (BYP && we_e && dstE == srcA) begin
            valA = valE;
        end
        if (BYP && we_m && dstM == srcB) begin
            valB = valM;
        end else if (BYP && we_e && dstE == srcB) begin
            valB = valE;
        end
    end

    // A pending source stalls decode unless its producer is writing back right now.
    always_comb begin
        covered_a = BYP && wb_en && (dstE == srcA || dstM == srcA);
        covered_b = BYP && wb_en && (dstE == srcB || dstM == srcB);
        stall     = 1'b0;
        if (is_valid(srcA) && pend[srcA] && !covered_a) begin
            stall = 1'b1;
        end
        if (is_valid(srcB) && pend[srcB] && !covered_b) begin
            stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Bench for y86_regfile_sb: bypassing and non-bypassing instances side by side,
// an array-based reference model, directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_y86_regfile_sb;

    localparam int unsigned NR = 15;
    localparam logic [63:0] SPR = 64'h100;

    logic        clk;
    logic        rst_n;
    logic [3:0]  srcA, srcB, dstE, dstM, mark_dstE, mark_dstM, dbg_addr;
    logic [63:0] valE, valM;
    logic        wb_en, mark_en;

    logic [63:0]   valA1, valB1, dbg1, valA0, valB0, dbg0;
    logic          stall1, stall0;
    logic [NR-1:0] pend1, pend0;

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    logic [63:0]   m_regs [NR];
    logic [NR-1:0] m_pend;

    y86_regfile_sb #(.BYPASS(1), .SP_RESET(SPR)) u_byp (
        .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .wb_en(wb_en),
        .mark_en(mark_en), .mark_dstE(mark_dstE), .mark_dstM(mark_dstM),
        .stall(stall1), .pend(pend1), .dbg_addr(dbg_addr), .dbg_data(dbg1)
    );

    y86_regfile_sb #(.BYPASS(0), .SP_RESET(SPR)) u_nob (
        .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .wb_en(wb_en),
        .mark_en(mark_en), .mark_dstE(mark_dstE), .mark_dstM(mark_dstM),
        .stall(stall0), .pend(pend0), .dbg_addr(dbg_addr), .dbg_data(dbg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as plain arrays.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_regs[i] = 64'h0;
            m_regs[4] = SPR;
            m_pend    = '0;
        end else begin
            logic [NR-1:0] np;
            np = m_pend;
            if (wb_en) begin
                if (dstE < NR) begin m_regs[dstE] = valE; np[dstE] = 1'b0; end
                if (dstM < NR) begin m_regs[dstM] = valM; np[dstM] = 1'b0; end
            end
            if (mark_en) begin
                if (mark_dstE < NR) np[mark_dstE] = 1'b1;
                if (mark_dstM < NR) np[mark_dstM] = 1'b1;
            end
            m_pend = np;
        end
    end

    function automatic logic [63:0] exp_rd(input logic [3:0] s, input bit byp);
        if (byp && wb_en && dstM < NR && dstM == s) return valM;
        if (byp && wb_en && dstE < NR && dstE == s) return valE;
        if (s < NR) return m_regs[s];
        return 64'h0;
    endfunction

    function automatic logic src_stall(input logic [3:0] s, input bit byp);
        if (s >= NR) return 1'b0;
        if (!m_pend[s]) return 1'b0;
        return !(byp && wb_en && (dstE == s || dstM == s));
    endfunction

    function automatic logic exp_stall(input bit byp);
        return src_stall(srcA, byp) || src_stall(srcB, byp);
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("valA_byp",  valA1,  exp_rd(srcA, 1'b1));
            chk("valB_byp",  valB1,  exp_rd(srcB, 1'b1));
            chk("valA_nob",  valA0,  exp_rd(srcA, 1'b0));
            chk("valB_nob",  valB0,  exp_rd(srcB, 1'b0));
            chk("stall_byp", 64'(stall1), 64'(exp_stall(1'b1)));
            chk("stall_nob", 64'(stall0), 64'(exp_stall(1'b0)));
            chk("pend_byp",  64'(pend1), 64'(m_pend));
            chk("pend_nob",  64'(pend0), 64'(m_pend));
            chk("dbg_byp",   dbg1, exp_rd(dbg_addr, 1'b0));
            chk("dbg_nob",   dbg0, exp_rd(dbg_addr, 1'b0));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wb_en = 1'b0; dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
        mark_en = 1'b0; mark_dstE = 4'hF; mark_dstM = 4'hF;
    endtask

    initial begin
        rst_n = 1'b1;
        srcA = 4'hF; srcB = 4'hF; dbg_addr = 4'h0;
        idle();
        #1 rst_n = 1'b0;
        repeat (2) step();
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Reset contents
        for (int i = 0; i < NR; i++) begin
            step();
            dbg_addr = 4'(i);
            #1 chk($sformatf("rst_reg%0d", i), dbg1, (i == 4) ? 64'h100 : 64'h0);
        end
        chk("rst_pend", 64'(pend1), 64'h0);
        chk("rst_stall", 64'(stall1), 64'h0);
        chk("rst_rnone", valA1, 64'h0);

        // Single write with bypass
        step();
        wb_en = 1'b1; dstE = 4'd3; valE = 64'hAA; srcA = 4'd3; dbg_addr = 4'd3;
        #1 chk("wr_bypass", valA1, 64'hAA);
        chk("wr_nobypass", valA0, 64'h0);
        chk("wr_dbg_old", dbg1, 64'h0);
        step();
        idle();
        #1 chk("wr_dbg_new", dbg1, 64'hAA);
        chk("wr_nob_new", valA0, 64'hAA);

        // E and M to the same register: M wins
        step();
        wb_en = 1'b1; dstE = 4'd4; valE = 64'h10; dstM = 4'd4; valM = 64'h20; srcA = 4'd4;
        #1 chk("em_bypass", valA1, 64'h20);
        step();
        idle();
        dbg_addr = 4'd4;
        #1 chk("em_stored", dbg1, 64'h20);

        // Scoreboard mark, stall, then clear via write-back
        step();
        mark_en = 1'b1; mark_dstE = 4'd2;
        step();
        idle();
        srcA = 4'd2;
        #1 chk("sb_pend2", 64'(pend1[2]), 64'h1);
        chk("sb_stall", 64'(stall1), 64'h1);
        step();
        wb_en = 1'b1; dstE = 4'd2; valE = 64'h99;
        #1 chk("sb_cover_byp", 64'(stall1), 64'h0);
        chk("sb_cover_nob", 64'(stall0), 64'h1);
        chk("sb_cover_val", valA1, 64'h99);
        step();
        idle();
        #1 chk("sb_cleared", 64'(pend1[2]), 64'h0);

        // Set wins over clear on the same register
        step();
        wb_en = 1'b1; dstM = 4'd5; valM = 64'h77; mark_en = 1'b1; mark_dstE = 4'd5;
        step();
        idle();
        dbg_addr = 4'd5;
        #1 chk("setwin_pend5", 64'(pend1[5]), 64'h1);
        chk("setwin_reg5", dbg1, 64'h77);

        // Asynchronous reset mid-cycle
        step();
        wb_en = 1'b1; dstE = 4'd7; valE = 64'h55; mark_en = 1'b1; mark_dstE = 4'd7;
        step();
        idle();
        dbg_addr = 4'd7;
        #1 chk("pre_rst_pend7", 64'(pend1[7]), 64'h1);
        chk("pre_rst_reg7", dbg1, 64'h55);
        rst_n = 1'b0;
        #1 chk("async_pend", 64'(pend1), 64'h0);
        chk("async_reg7", dbg1, 64'h0);
        step();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            rst_n     = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            srcA      = 4'($urandom_range(0, 15));
            srcB      = 4'($urandom_range(0, 15));
            dbg_addr  = 4'($urandom_range(0, 15));
            wb_en     = ($urandom_range(0, 4) != 0);
            dstE      = 4'($urandom_range(0, 15));
            dstM      = 4'($urandom_range(0, 15));
            valE      = {$urandom, $urandom};
            valM      = {$urandom, $urandom};
            mark_en   = ($urandom_range(0, 2) == 0);
            mark_dstE = 4'($urandom_range(0, 15));
            mark_dstM = 4'($urandom_range(0, 15));
        end

        step();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/y86_regfile_sb.md
Name: y86_regfile_sb

Overview:
- Clocked, parametrised Y86 register file that replaces the combinational decode/write-back register array.
- Two read ports (decode A/B) and two write ports (E from execute, M from memory), with optional write-to-read bypass.
- A per-register pending-write scoreboard drives a decode stall for the pipelined core.
- Sits between the decode and write-back stages; a debug port exposes any register to the bench.

Parameters:
DATA_W, 64, register width in bits
NUM_REGS, 15, number of architectural registers (indices 0..NUM_REGS-1)
ADDR_W, 4, register index width; the all-ones index (RNONE, 0xF at default) means "no register"
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored contents only
SP_IDX, 4, stack-pointer index (%rsp)
SP_RESET, 64'h0, reset value of register SP_IDX; all other registers reset to 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
srcA  in  ADDR_W  read port A index
srcB  in  ADDR_W  read port B index
valA  out  DATA_W  read data A (combinational)
valB  out  DATA_W  read data B (combinational)
dstE  in  ADDR_W  E write index; RNONE = no write
valE  in  DATA_W  E write data
dstM  in  ADDR_W  M write index; RNONE = no write
valM  in  DATA_W  M write data
wb_en  in  1  global write enable; 0 blocks both writes (write-back bubble)
mark_en  in  1  decode issue: mark mark_dstE/mark_dstM pending
mark_dstE  in  ADDR_W  producer destination for E; RNONE = none
mark_dstM  in  ADDR_W  producer destination for M; RNONE = none
stall  out  1  decode must hold: a source register is pending and not bypassed
pend  out  NUM_REGS  scoreboard bits, bit i = register i pending
dbg_addr  in  ADDR_W  debug read index
dbg_data  out  DATA_W  debug read data, stored contents only, never bypassed

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0 except reg[SP_IDX] = SP_RESET; pend = 0. stall is then 0 by construction. Deassertion is sampled at the next clk edge.
- Valid index: ADDR_W value < NUM_REGS. RNONE or any index >= NUM_REGS reads 0, is never written, and never marks pending.
- Write (rising edge, wb_en=1): reg[dstE] <= valE if dstE valid; reg[dstM] <= valM if dstM valid.
- dstE == dstM (both valid): M wins. This is the popq %rsp rule.
- Write latency: the value is stored at the edge and visible on valA/valB/dbg_data in the following cycle.
- Read, BYPASS=1, priority order:
  - M write hit (wb_en and dstM == src) returns valM.
  - Otherwise E write hit returns valE.
  - Otherwise stored contents.
- Read, BYPASS=0: stored contents only.
- Read ports are independent; srcA == srcB returns the same value on both.
- Scoreboard update at each edge, for each register i:
  - clear if a valid write to i occurs (wb_en=1, dstE==i or dstM==i);
  - set if mark_en=1 and (mark_dstE==i or mark_dstM==i);
  - set and clear together on the same register: set wins (the newer producer is still outstanding).
- Scoreboard depth: one outstanding producer per register. Decode stalls before issuing a second producer to a pending register. Marking an already-pending register is legal and leaves it set.
- stall (combinational): asserted when, for srcA or srcB:
  - the index is valid, and
  - pend[src] = 1, and
  - it is not covered by a same-cycle write, i.e. not (BYPASS=1 and wb_en=1 and (dstE==src or dstM==src)).
  - With BYPASS=0, any pending source stalls, even one written that cycle.
- wb_en=0: no register or scoreboard clears; marks still apply.
- Reset asserted mid-operation: registers and pend return to reset values immediately; in-flight writes are lost.

Test Plan:
1. Reset with SP_RESET=64'h100 -> dbg reads of reg4 = 0x100 and reg0..reg14 (except 4) = 0; pend=0; stall=0; srcA=0xF gives valA=0.
2. wb_en=1, dstE=3, valE=0xAA; next cycle dstE=0xF -> during the write cycle valA(srcA=3)=0xAA via bypass, dbg_data(3) still 0; next cycle dbg_data(3)=0xAA. With BYPASS=0, valA=0 in the write cycle.
3. dstE=4 valE=0x10, dstM=4 valM=0x20 in one edge -> reg4=0x20, and bypassed valA(srcA=4)=0x20 during that cycle.
4. mark_en, mark_dstE=2; next cycle srcA=2 -> pend[2]=1 and stall=1. Then wb_en with dstE=2 -> stall=0 in that cycle (BYPASS=1) and pend[2]=0 after the edge.
5. In one cycle, write dstM=5 plus mark_en with mark_dstE=5 -> pend[5] stays 1 after the edge; reg5 is updated.
6. pend[7] set and reg7=0x55, then rst_n pulsed low mid-cycle -> pend=0 and reg7=0 immediately, before the next clk edge.
